// File: rtl/sip_lif_core.sv
// sip_lif_core: serial synaptic accumulator feeding a leaky integrate-and-fire neuron.
// Optional macro SIP_SPARSE_SCAN_EN: scan only set spike bits, lowest index first.
module sip_lif_core #(
  parameter int N_SYN          = 16,
  parameter int W_W            = 4,
  parameter int V_W            = 12,
  parameter int THRESHOLD      = 40,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     w_we,
  input  logic [$clog2(N_SYN)-1:0] w_addr,
  input  logic [W_W-1:0]           w_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_SYN-1:0]         spike_in,
  input  logic [N_SYN-1:0]         ein,
  output logic                     spike,
  output logic                     done,
  output logic                     flush_weight,
  output logic signed [V_W-1:0]    v_mem
);

  localparam int A_W  = $clog2(N_SYN);
  localparam int RC_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic signed [V_W:0] V_MAX = {2'b00, {(V_W-1){1'b1}}};
  localparam logic signed [V_W:0] V_MIN = {2'b11, {(V_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, REFRACT} state_t;

  // One guard bit is enough because V_W > W_W + 1.
  function automatic logic signed [V_W-1:0] sat_acc(input logic signed [V_W-1:0] v,
                                                    input logic [W_W-1:0] w,
                                                    input logic add);
    logic signed [V_W:0] vx;
    logic signed [V_W:0] wz;
    logic signed [V_W:0] wide;
    vx   = {v[V_W-1], v};
    wz   = {{(V_W+1-W_W){1'b0}}, w};
    wide = add ? (vx + wz) : (vx - wz);
    if (wide > V_MAX) return V_MAX[V_W-1:0];
    if (wide < V_MIN) return V_MIN[V_W-1:0];
    return wide[V_W-1:0];
  endfunction

  function automatic logic signed [V_W-1:0] leak(input logic signed [V_W-1:0] v);
    if (LEAK_SHIFT == 0) return v;
    return v - (v >>> LEAK_SHIFT);
  endfunction

  state_t                state, state_nxt;
  logic [W_W-1:0]        weights [N_SYN];
  logic [N_SYN-1:0]      spk_lat, ein_lat;
  logic [A_W-1:0]        cur_idx;
  logic                  last_syn, start_scan, fire;
  logic signed [V_W-1:0] v_leak;
  logic [RC_W-1:0]       rcnt;

`ifdef SIP_SPARSE_SCAN_EN
  function automatic logic [A_W-1:0] lowest_set(input logic [N_SYN-1:0] m);
    logic [A_W-1:0] r;
    r = '0;
    for (int i = N_SYN - 1; i >= 0; i--) if (m[i]) r = A_W'(i);
    return r;
  endfunction

  // The latched mask doubles as the work list; each scan step clears its lowest bit.
  logic [N_SYN-1:0] spk_rest;
  assign cur_idx    = lowest_set(spk_lat);
  assign spk_rest   = spk_lat & (spk_lat - N_SYN'(1));
  assign last_syn   = (spk_rest == '0);
  assign start_scan = (spike_in != '0);
`else
  logic [A_W-1:0] idx;
  assign cur_idx    = idx;
  assign last_syn   = (int'(idx) == N_SYN - 1);
  assign start_scan = 1'b1;
`endif

  assign v_leak = leak(v_mem);
  assign fire   = (int'(v_leak) >= THRESHOLD);

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    flush_weight = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = start_scan ? SCAN : UPDATE;
      end
      SCAN:    if (last_syn) state_nxt = UPDATE;
      UPDATE: begin
        flush_weight = 1'b1;
        state_nxt    = (fire && REFRACT_CYCLES > 0) ? REFRACT : IDLE;
      end
      REFRACT: if (rcnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      v_mem <= '0;
      spike <= 1'b0;
      done  <= 1'b0;
      rcnt  <= '0;
`ifndef SIP_SPARSE_SCAN_EN
      idx   <= '0;
`endif
    end else begin
      state <= state_nxt;
      spike <= 1'b0;
      done  <= 1'b0;
      case (state)
        SCAN: begin
          if (spk_lat[cur_idx]) v_mem <= sat_acc(v_mem, weights[cur_idx], ein_lat[cur_idx]);
`ifndef SIP_SPARSE_SCAN_EN
          idx <= idx + A_W'(1);
`endif
        end
        UPDATE: begin
          done <= 1'b1;
          if (fire) begin
            v_mem <= '0;
            spike <= 1'b1;
            rcnt  <= RC_W'(REFRACT_CYCLES - 1);
          end else begin
            v_mem <= v_leak;
          end
        end
        REFRACT: rcnt <= rcnt - RC_W'(1);
        default: begin
`ifndef SIP_SPARSE_SCAN_EN
          idx <= '0;
`endif
        end
      endcase
    end
  end

  // Vector latches carry no reset: they are only read after a fresh handshake.
  always_ff @(posedge clock) begin
    if (state == IDLE && in_valid) begin
      spk_lat <= spike_in;
      ein_lat <= ein;
    end
`ifdef SIP_SPARSE_SCAN_EN
    else if (state == SCAN) begin
      spk_lat <= spk_rest;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_SYN; i++) weights[i] <= '0;
    end else if (w_we && int'(w_addr) < N_SYN) begin
      weights[w_addr] <= w_data;
    end
  end

endmodule
